// File: rtl/sigdelay_pkg.sv
// Shared types for the multi-mode sample delay line: mode encodings, FSM
// states and the guard-bit rule used by the saturating adders.
package sigdelay_pkg;

  typedef enum logic [1:0] {
    MODE_DLY  = 2'b00,
    MODE_MIX  = 2'b01,
    MODE_ECHO = 2'b10,
    MODE_BYP  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FILL = 2'b01,
    ST_RUN  = 2'b10
  } state_e;

  // Sums are formed this many bits wider than a sample, then clamped.
  localparam int SAT_GUARD_W = 1;

endpackage

// File: rtl/sigdelay_mc_ram2ports.sv
// Sample store: one synchronous write port, one registered read port.
// Contents are intentionally not reset.
module ram2ports #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [A_WIDTH-1:0] waddr,
  input  logic [D_WIDTH-1:0] wdata,
  input  logic               re,
  input  logic [A_WIDTH-1:0] raddr,
  output logic [D_WIDTH-1:0] rdata
);

  logic [D_WIDTH-1:0] mem_q [2**A_WIDTH];
  logic [D_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sigdelay_mc.sv
// Multi-mode delay line: delayed-only, dry+delayed mix, echo with feedback,
// and bypass. Two-stage pipeline around a synchronous-read sample RAM.
module sigdelay_mc
  import sigdelay_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [A_WIDTH-1:0] delay,
  input  logic [1:0]         mode,
  input  logic [D_WIDTH-1:0] mic_signal,
  output logic [D_WIDTH-1:0] delayed_signal,
  output logic               out_valid,
  output logic               filled
);

  localparam int SUM_W = D_WIDTH + SAT_GUARD_W;

  function automatic logic [D_WIDTH-1:0] sat_add(input logic [D_WIDTH-1:0] a,
                                                 input logic [D_WIDTH-1:0] b);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(a) + SUM_W'(b);
    if (sum[SUM_W-1:D_WIDTH] != '0) return '1;
    return sum[D_WIDTH-1:0];
  endfunction

  state_e             state_q, state_d, st_pre;
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] delay_q, delay_d, dly_eff;
  logic [A_WIDTH-1:0] fill_cnt_q, fill_cnt_d, cnt_pre;
  logic               vld_p1_q, vld_p1_d;
  logic               out_valid_q, out_valid_d;
  logic [D_WIDTH-1:0] dout_q, dout_d;

  logic [D_WIDTH-1:0] in_p1_q, in_p1_d;
  logic [A_WIDTH-1:0] addr_p1_q, addr_p1_d;
  mode_e              mode_p1_q, mode_p1_d;
  logic               fill_p1_q, fill_p1_d;
  logic               dly0_p1_q, dly0_p1_d;

  logic [A_WIDTH-1:0] rd_addr;
  logic [D_WIDTH-1:0] rd_data;
  logic [D_WIDTH-1:0] delayed_term, result, wr_data;

  // Stage 1: delay latch, FSM/fill update, input capture, RAM read issue.
  // A sample accepted in FILL is gated; a delay change counts its own sample.
  always_comb begin
    state_d    = state_q;
    delay_d    = delay_q;
    fill_cnt_d = fill_cnt_q;
    st_pre     = state_q;
    cnt_pre    = fill_cnt_q;
    dly_eff    = delay_q;
    in_p1_d    = in_p1_q;
    addr_p1_d  = addr_p1_q;
    mode_p1_d  = mode_p1_q;
    fill_p1_d  = fill_p1_q;
    dly0_p1_d  = dly0_p1_q;
    vld_p1_d   = en;
    if (en) begin
      if (delay != delay_q) begin
        dly_eff = delay;
        delay_d = delay;
        st_pre  = ST_FILL;
        cnt_pre = '0;
      end else if (state_q == ST_IDLE) begin
        st_pre  = ST_FILL;
        cnt_pre = '0;
      end
      if (st_pre == ST_FILL) begin
        fill_cnt_d = (cnt_pre != dly_eff) ? cnt_pre + A_WIDTH'(1) : cnt_pre;
        state_d    = (fill_cnt_d == dly_eff) ? ST_RUN : ST_FILL;
      end
      in_p1_d   = mic_signal;
      addr_p1_d = wr_ptr_q;
      mode_p1_d = mode_e'(mode);
      fill_p1_d = (st_pre != ST_RUN);
      dly0_p1_d = (dly_eff == '0);
    end
    rd_addr = wr_ptr_q - dly_eff;
  end

  // Stage 2: combine with delayed term, write RAM, register the output.
  always_comb begin
    delayed_term = dly0_p1_q ? in_p1_q : (fill_p1_q ? '0 : rd_data);
    result       = delayed_term;
    wr_data      = in_p1_q;
    case (mode_p1_q)
      MODE_DLY:  result = delayed_term;
      MODE_MIX:  result = sat_add(in_p1_q, delayed_term);
      MODE_ECHO: begin
        result  = sat_add(in_p1_q, delayed_term >> 1);
        wr_data = result;
      end
      default:   result = in_p1_q;
    endcase
    dout_d      = dout_q;
    wr_ptr_d    = wr_ptr_q;
    out_valid_d = vld_p1_q;
    if (vld_p1_q) begin
      dout_d   = result;
      wr_ptr_d = wr_ptr_q + A_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      delay_q     <= '0;
      fill_cnt_q  <= '0;
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      delay_q     <= delay_d;
      fill_cnt_q  <= fill_cnt_d;
      vld_p1_q    <= vld_p1_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    in_p1_q   <= in_p1_d;
    addr_p1_q <= addr_p1_d;
    mode_p1_q <= mode_p1_d;
    fill_p1_q <= fill_p1_d;
    dly0_p1_q <= dly0_p1_d;
  end

  ram2ports #(
    .A_WIDTH(A_WIDTH),
    .D_WIDTH(D_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (vld_p1_q),
    .waddr(addr_p1_q),
    .wdata(wr_data),
    .re   (en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  assign delayed_signal = dout_q;
  assign out_valid      = out_valid_q;
  assign filled         = (state_q == ST_RUN);

endmodule

// File: tb/tb_sigdelay_mc.sv
// Directed bench for sigdelay_mc: a default-size instance plus a depth-8
// instance sharing the same stimulus, checked against hand-computed vectors.
module tb_sigdelay_mc;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] dly;
  logic [1:0] mode;
  logic [7:0] mic;
  logic [7:0] ds_a, ds_b;
  logic       ov_a, ov_b, fl_a, fl_b;

  int checks;
  int errors;

  sigdelay_mc #(.A_WIDTH(8), .D_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .en(en), .delay(dly), .mode(mode),
    .mic_signal(mic), .delayed_signal(ds_a), .out_valid(ov_a), .filled(fl_a)
  );

  sigdelay_mc #(.A_WIDTH(3), .D_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .delay(dly[2:0]), .mode(mode),
    .mic_signal(mic), .delayed_signal(ds_b), .out_valid(ov_b), .filled(fl_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One en pulse, then two idle cycles; observations mid-cycle 1 and 2.
  task automatic send(input logic [7:0] s, output logic ov1, output logic fl,
                      output logic ov2, output logic [7:0] da,
                      output logic [7:0] db, output logic ovb);
    @(negedge clk);
    mic = s;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    ov1 = ov_a;
    fl  = fl_a;
    @(negedge clk);
    ov2 = ov_a;
    da  = ds_a;
    db  = ds_b;
    ovb = ov_b;
  endtask

  task automatic test_reset();
    en = 1'b0; dly = '0; mode = 2'b00; mic = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (ds_a !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d want 0", ds_a); end
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ov_a); end
    checks++; if (fl_a !== 1'b0) begin errors++; $display("FAIL reset_filled: got %b want 0", fl_a); end
    checks++; if (fl_b !== 1'b0 || ov_b !== 1'b0) begin errors++; $display("FAIL reset_b: filled %b valid %b want 0 0", fl_b, ov_b); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] ins [5];
    logic [7:0] exp [5];
    logic       efl [5];
    logic       ov1, fl, ov2, ovb;
    logic [7:0] da, db;
    ins = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50};
    exp = '{8'd0, 8'd0, 8'd0, 8'd10, 8'd20};
    efl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    dly = 8'd3; mode = 2'b00;
    for (int i = 0; i < 5; i++) begin
      send(ins[i], ov1, fl, ov2, da, db, ovb);
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, ov1); end
      checks++; if (ov2 !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b want 1", i, ov2); end
      checks++; if (fl !== efl[i]) begin errors++; $display("FAIL basic_filled[%0d]: got %b want %b", i, fl, efl[i]); end
      checks++; if (da !== exp[i]) begin errors++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, da, exp[i]); end
    end
    @(negedge clk);
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse_width: got %b want 0", ov_a); end
  endtask

  task automatic test_delay0_bypass();
    logic       ov1, fl, ov2, ovb;
    logic [7:0] da, db;
    do_reset();
    dly = 8'd0; mode = 2'b00;
    send(8'd77, ov1, fl, ov2, da, db, ovb);
    checks++; if (da !== 8'd77) begin errors++; $display("FAIL delay0_data: got %0d want 77", da); end
    checks++; if (fl !== 1'b1) begin errors++; $display("FAIL delay0_filled: got %b want 1", fl); end
    do_reset();
    dly = 8'd2; mode = 2'b11;
    send(8'd5, ov1, fl, ov2, da, db, ovb);
    checks++; if (da !== 8'd5 || fl !== 1'b0) begin errors++; $display("FAIL bypass_first: data %0d filled %b want 5 0", da, fl); end
    send(8'd6, ov1, fl, ov2, da, db, ovb);
    checks++; if (da !== 8'd6 || fl !== 1'b1) begin errors++; $display("FAIL bypass_second: data %0d filled %b want 6 1", da, fl); end
  endtask

  task automatic test_wrap();
    logic       ov1, fl, ov2, ovb;
    logic [7:0] da, db, exp;
    do_reset();
    dly = 8'd7; mode = 2'b00;
    for (int k = 1; k <= 20; k++) begin
      send(8'(k), ov1, fl, ov2, da, db, ovb);
      exp = (k <= 7) ? 8'd0 : 8'(k - 7);
      checks++; if (ovb !== 1'b1) begin errors++; $display("FAIL wrap_valid[%0d]: got %b want 1", k, ovb); end
      checks++; if (db !== exp) begin errors++; $display("FAIL wrap_data[%0d]: got %0d want %0d", k, db, exp); end
    end
    checks++; if (fl_b !== 1'b1) begin errors++; $display("FAIL wrap_filled: got %b want 1", fl_b); end
  endtask

  task automatic test_mix();
    logic [7:0] ins [4];
    logic [7:0] exp [4];
    logic       ov1, fl, ov2, ovb;
    logic [7:0] da, db;
    ins = '{8'd200, 8'd100, 8'd10, 8'd20};
    exp = '{8'd200, 8'd255, 8'd110, 8'd30};
    do_reset();
    dly = 8'd1; mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      send(ins[i], ov1, fl, ov2, da, db, ovb);
      checks++; if (da !== exp[i]) begin errors++; $display("FAIL mix_data[%0d]: got %0d want %0d", i, da, exp[i]); end
    end
    mode = 2'b00;
    send(8'd50, ov1, fl, ov2, da, db, ovb);
    checks++; if (da !== 8'd20 || fl !== 1'b1) begin errors++; $display("FAIL mode_change: data %0d filled %b want 20 1", da, fl); end
  endtask

  task automatic test_echo();
    logic [7:0] exp [7];
    logic       ov1, fl, ov2, ovb;
    logic [7:0] da, db;
    exp = '{8'd128, 8'd0, 8'd64, 8'd0, 8'd32, 8'd0, 8'd16};
    do_reset();
    dly = 8'd2; mode = 2'b10;
    for (int i = 0; i < 7; i++) begin
      send((i == 0) ? 8'd128 : 8'd0, ov1, fl, ov2, da, db, ovb);
      checks++; if (da !== exp[i]) begin errors++; $display("FAIL echo_data[%0d]: got %0d want %0d", i, da, exp[i]); end
    end
    do_reset();
    dly = 8'd1; mode = 2'b10;
    send(8'd200, ov1, fl, ov2, da, db, ovb);
    send(8'd200, ov1, fl, ov2, da, db, ovb);
    checks++; if (da !== 8'd255) begin errors++; $display("FAIL echo_saturate: got %0d want 255", da); end
  endtask

  task automatic test_delay_change();
    logic [7:0] exp [10];
    logic       efl [10];
    logic       ov1, fl, ov2, ovb;
    logic [7:0] da, db;
    exp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd7, 8'd8};
    efl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    dly = 8'd4; mode = 2'b00;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) dly = 8'd2;
      send(8'(i + 1), ov1, fl, ov2, da, db, ovb);
      checks++; if (da !== exp[i]) begin errors++; $display("FAIL dchange_data[%0d]: got %0d want %0d", i, da, exp[i]); end
      checks++; if (fl !== efl[i]) begin errors++; $display("FAIL dchange_filled[%0d]: got %b want %b", i, fl, efl[i]); end
    end
  endtask

  task automatic test_rst_mid();
    do_reset();
    dly = 8'd0; mode = 2'b11;
    @(negedge clk);
    mic = 8'd99;
    en  = 1'b1;
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (fl_a !== 1'b0) begin errors++; $display("FAIL rstmid_filled: got %b want 0", fl_a); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ov_a !== 1'b0 || ds_a !== 8'd0) begin errors++; $display("FAIL rstmid_out[%0d]: valid %b data %0d want 0 0", i, ov_a, ds_a); end
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    test_reset();
    test_basic();
    test_delay0_bypass();
    test_wrap();
    test_mix();
    test_echo();
    test_delay_change();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sigdelay_mc.md
SIGDELAY_MC -- requirements
Module: sigdelay_mc

Interface
Parameters:
REQ-001 A_WIDTH, 8, buffer address width; depth = 2^A_WIDTH samples.
REQ-002 D_WIDTH, 8, unsigned sample width.

Ports:
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  sample strobe; one input sample per en pulse.
REQ-006 delay  input  A_WIDTH  requested delay in samples, 0..2^A_WIDTH-1.
REQ-007 mode  input  2  00 delayed-only, 01 dry+delayed mix, 10 echo (feedback), 11 bypass.
REQ-008 mic_signal  input  D_WIDTH  input sample, sampled when en=1.
REQ-009 delayed_signal  output  D_WIDTH  registered output sample.
REQ-010 out_valid  output  1  one-cycle pulse marking a new delayed_signal.
REQ-011 filled  output  1  high when the buffer holds at least delay valid samples.

Function
REQ-012 en SHALL be applied with at least one idle cycle between pulses; behaviour with back-to-back en is undefined and the bench SHALL not drive it.
REQ-013 Pipeline: stage 1 (en cycle) latches the input sample, write address and mode, and issues a synchronous RAM read at (wr_ptr - delay_q) mod 2^A_WIDTH. Stage 2 (en+1) computes the result, writes the RAM, and registers delayed_signal; out_valid pulses high on the cycle after stage 2 (en+2).
REQ-014 wr_ptr SHALL increment by 1 per en after the stage-2 write and wrap from 2^A_WIDTH-1 to 0.
REQ-015 Delay is latched into delay_q on an en cycle whenever delay != delay_q; a latch enters FILL and clears fill_cnt.
REQ-016 FSM states: IDLE (after reset, before first en) -> FILL on first en; FILL -> RUN when fill_cnt reaches delay_q; RUN -> FILL on a delay change; any state -> IDLE on rst.
REQ-017 fill_cnt SHALL saturate at delay_q; filled = (state == RUN).
REQ-018 In FILL, the delayed term SHALL be treated as 0; stale RAM contents SHALL never reach the output.
REQ-019 delay_q = 0 SHALL make the delayed term equal the current input sample, with no RAM read used; FILL completes immediately.
REQ-020 Mode 00: output = delayed term.
REQ-021 Mode 01: output = min(input + delayed, 2^D_WIDTH-1), computed at D_WIDTH+1 bits and then saturated.
REQ-022 Mode 10: w = min(input + (delayed >> 1), 2^D_WIDTH-1); w is written to RAM and w is also the output.
REQ-023 Modes 00, 01 and 11 write the raw input to RAM.
REQ-024 Mode 11: output = input; the FSM and the pointer advance normally.
REQ-025 A mode change takes effect from the next en and SHALL NOT restart FILL.

Reset
REQ-026 rst SHALL asynchronously clear wr_ptr, delay_q, fill_cnt, the pipeline valid bits, delayed_signal, out_valid and filled to 0, and set the FSM to IDLE; RAM contents are not cleared.
REQ-027 rst asserted mid-pipeline SHALL cancel any pending stage-2 write and any pending out_valid pulse.

Structure
REQ-028 The mode encodings, the FSM state enum and the saturating-add width rule SHALL live in the shared package sigdelay_pkg.
REQ-029 Storage SHALL use a single sub-module, ram2ports (synchronous read, one write port), parametrised by A_WIDTH and D_WIDTH.
REQ-030 The pointer and fill counting SHALL be inline, with no separate counter instance.

Verification
REQ-031 Reset, then delay=3, mode=00, inputs 10,20,30,40,50 -> outputs 0,0,0,10,20; filled rises on the 3rd en; out_valid is high exactly 2 cycles after each en.
REQ-032 delay=0, mode=00, input 77 -> output 77 with filled=1 after the first en.
REQ-033 A_WIDTH=3, delay=7, 20 ramp samples -> output equals the input from 7 samples earlier across pointer wrap.
REQ-034 Mode 01, delay=1, inputs 200 then 100 -> 2nd output 255 (saturated); inputs 10 then 20 -> 30.
REQ-035 Mode 10, delay=2, impulse 128 followed by zeros -> outputs 128,0,64,0,32,0,16.
REQ-036 RUN with delay=4, change delay to 2 mid-stream -> filled drops for 2 samples and the outputs are 0 during FILL; rst pulsed between en and en+2 -> no out_valid, all outputs 0.
